// File: rtl/sdp_ram_reader.sv
// sdp_ram_reader: streams a run of consecutive words from a registered-read SDP RAM onto a valid/ready port.
// Build macro SDP_READER_WRAP_EN lets a transfer wrap from address DEPTH-1 back to 0.
module sdp_ram_reader #(
    parameter int WIDTH = 640,
    parameter int DEPTH = 480,
    localparam int ADDRW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [ADDRW-1:0] i_base_addr,
    input  logic [ADDRW:0]   i_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_rd_req,
    output logic [ADDRW-1:0] o_rd_addr,
    input  logic [WIDTH-1:0] i_rd_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_last
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [ADDRW:0]   rem_q, rem_d;
    logic             done_q, done_d;
    logic             inflight_q, inflight_last_q;
    logic [WIDTH-1:0] buf_data_q [2];
    logic [1:0]       buf_last_q;
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       occ_q, occ_d;

    logic             valid_s, pop_s, rd_req_s, last_issue_s, legal_s, head_last_s;
    logic [2:0]       pending_s;
    logic [ADDRW-1:0] addr_inc_s;

    assign valid_s      = (occ_q != 2'd0);
    assign head_last_s  = valid_s & buf_last_q[rd_ptr_q];
    assign pop_s        = valid_s & i_ready;
    // Words that will still be buffered or in flight next cycle if no new read is issued.
    assign pending_s    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    assign rd_req_s     = (state_q == ST_RUN) && (pending_s < 3'd2);
    assign last_issue_s = rd_req_s && (rem_q == (ADDRW+1)'(1));
    assign addr_inc_s   = (addr_q == ADDRW'(DEPTH - 1)) ? {ADDRW{1'b0}} : addr_q + ADDRW'(1);
    assign occ_d        = occ_q + {1'b0, inflight_q} - {1'b0, pop_s};

`ifdef SDP_READER_WRAP_EN
    assign legal_s = 1'b1;
`else
    logic [ADDRW+1:0] span_s;
    assign span_s  = {2'b00, i_base_addr} + {1'b0, i_count};
    assign legal_s = (span_s <= (ADDRW+2)'(DEPTH));
`endif

    // Sequencer next state: start capture, read issue bookkeeping, completion detection.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if ((i_count == (ADDRW+1)'(0)) || !legal_s) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = i_base_addr;
                        rem_d   = i_count;
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rd_req_s) begin
                    addr_d = addr_inc_s;
                    rem_d  = rem_q - (ADDRW+1)'(1);
                    if (last_issue_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pop_s && head_last_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, in-flight tracking and the two-entry output buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= ST_IDLE;
            addr_q          <= {ADDRW{1'b0}};
            rem_q           <= {(ADDRW+1){1'b0}};
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_data_q[0]   <= {WIDTH{1'b0}};
            buf_data_q[1]   <= {WIDTH{1'b0}};
            buf_last_q      <= 2'b00;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            occ_q           <= 2'd0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            done_q          <= done_d;
            inflight_q      <= rd_req_s;
            inflight_last_q <= last_issue_s;
            occ_q           <= occ_d;
            if (inflight_q) begin
                buf_data_q[wr_ptr_q] <= i_rd_data;
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign o_busy    = (state_q != ST_IDLE);
    assign o_done    = done_q;
    assign o_rd_req  = rd_req_s;
    assign o_rd_addr = addr_q;
    assign o_data    = buf_data_q[rd_ptr_q];
    assign o_valid   = valid_s;
    assign o_last    = head_last_s;

endmodule

// File: tb/tb_sdp_ram_reader.sv
// Testbench for sdp_ram_reader: behavioural registered-read RAM plus a queue scoreboard for addresses and words.
module tb_sdp_ram_reader;
    localparam int WIDTH = 640;
    localparam int DEPTH = 480;
    localparam int ADDRW = $clog2(DEPTH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, start, ready;
    logic [ADDRW-1:0] base;
    logic [ADDRW:0]   count;
    logic [WIDTH-1:0] rd_data;
    logic             busy, done, rd_req, valid, last;
    logic [ADDRW-1:0] rd_addr;
    logic [WIDTH-1:0] data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [ADDRW-1:0] q_addr[$];
    logic [WIDTH-1:0] q_data[$];
    logic             q_last[$];
    int               issued = 0;
    int               popped = 0;
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;

    sdp_ram_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base), .i_count(count),
        .o_busy(busy), .o_done(done), .o_rd_req(rd_req), .o_rd_addr(rd_addr),
        .i_rd_data(rd_data), .o_data(data), .o_valid(valid), .i_ready(ready), .o_last(last)
    );

    function automatic logic [WIDTH-1:0] word_of(input int a);
        logic [WIDTH-1:0] w;
        for (int i = 0; i < WIDTH / 32; i++) w[i*32 +: 32] = 32'(a) * 32'h9E3779B1 + 32'(i);
        return w;
    endfunction

    always @(posedge clk) if (rd_req) rd_data <= word_of(int'(rd_addr));

    // Scoreboard: read addresses, popped words, stall stability and outstanding-word bound.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rd_req) begin
                issued++;
                n_cmp++;
                if (q_addr.size() == 0) begin
                    n_bad++; $display("FAIL rd_addr_unexpected got %0d want none", rd_addr);
                end else if (rd_addr !== q_addr[0]) begin
                    n_bad++; $display("FAIL rd_addr got %0d want %0d", rd_addr, q_addr[0]);
                    void'(q_addr.pop_front());
                end else begin
                    void'(q_addr.pop_front());
                end
            end
            if (stall_prev) begin
                n_cmp++;
                if ({data, last} !== {prev_data, prev_last}) begin
                    n_bad++; $display("FAIL stall_stable got last=%b %h want last=%b %h", last, data, prev_last, prev_data);
                end
            end
            if (valid && ready) begin
                popped++;
                n_cmp++;
                if (q_data.size() == 0) begin
                    n_bad++; $display("FAIL word_unexpected got %h want none", data);
                end else begin
                    if ({data, last} !== {q_data[0], q_last[0]}) begin
                        n_bad++; $display("FAIL word got last=%b %h want last=%b %h", last, data, q_last[0], q_data[0]);
                    end
                    void'(q_data.pop_front());
                    void'(q_last.pop_front());
                end
            end
            n_cmp++;
            if (issued - popped > 2) begin
                n_bad++; $display("FAIL outstanding got %0d want <=2", issued - popped);
            end
            stall_prev = valid && !ready;
            prev_data  = data;
            prev_last  = last;
        end
    end

    task automatic do_start(input int b, input int c, input bit reads);
        base  = ADDRW'(b);
        count = (ADDRW+1)'(c);
        start = 1'b1;
        if (reads) begin
            for (int i = 0; i < c; i++) begin
                q_addr.push_back(ADDRW'((b + i) % DEPTH));
                q_data.push_back(word_of((b + i) % DEPTH));
                q_last.push_back(i == c - 1);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output int k_done);
        k_done = -1;
        for (int k = 1; k <= budget; k++) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (done) begin
                k_done = k;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ready = 1'b0; base = '0; count = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, rd_req, valid, last} !== 5'b00000) begin
            n_bad++; $display("FAIL reset_flags got %b want 00000", {busy, done, rd_req, valid, last});
        end
        n_cmp++;
        if (rd_addr !== {ADDRW{1'b0}}) begin
            n_bad++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr);
        end
        n_cmp++;
        if (data !== {WIDTH{1'b0}}) begin
            n_bad++; $display("FAIL reset_data got %h want 0", data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [4:0] exp_v;
        ready = 1'b1;
        do_start(10, 4, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_v = {(k <= 6), (k <= 4), (k >= 3 && k <= 6), (k == 6), (k == 7)};
            n_cmp++;
            if ({busy, rd_req, valid, last, done} !== exp_v) begin
                n_bad++; $display("FAIL basic_timing T+%0d got busy/req/valid/last/done=%b want %b", k, {busy, rd_req, valid, last, done}, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int kd;
        for (int rep = 0; rep < 3; rep++) begin
            do_start(10, 4, 1'b1);
            wait_done(200, 1'b1, kd);
            n_cmp++;
            if (kd < 0) begin
                n_bad++; $display("FAIL bp_done_timeout rep %0d got none want done", rep);
            end
            n_cmp++;
            if (q_data.size() + q_addr.size() != 0) begin
                n_bad++; $display("FAIL bp_leftover got %0d want 0", q_data.size() + q_addr.size());
            end
            @(posedge clk); #1;
        end
        ready = 1'b1;
    endtask

    task automatic test_zero_and_edge();
        int kd;
        do_start(5, 0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({rd_req, valid, busy, done} !== {3'b000, (k == 1)}) begin
                n_bad++; $display("FAIL zero_count T+%0d got req/valid/busy/done=%b want %b", k, {rd_req, valid, busy, done}, {3'b000, (k == 1)});
            end
            @(posedge clk); #1;
        end
        do_start(DEPTH - 1, 1, 1'b1);
        wait_done(20, 1'b0, kd);
        n_cmp++;
        if (kd !== 4) begin
            n_bad++; $display("FAIL single_word_done got T+%0d want T+4", kd);
        end
    endtask

    task automatic test_wrap();
        int kd;
`ifdef SDP_READER_WRAP_EN
        do_start(DEPTH - 2, 4, 1'b1);
        wait_done(30, 1'b0, kd);
        n_cmp++;
        if (kd !== 7) begin
            n_bad++; $display("FAIL wrap_done got T+%0d want T+7", kd);
        end
`else
        do_start(DEPTH - 2, 4, 1'b0);
        wait_done(30, 1'b0, kd);
        n_cmp++;
        if (kd !== 1) begin
            n_bad++; $display("FAIL reject_done got T+%0d want T+1", kd);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_and_reset();
        int kd;
        ready = 1'b0;
        do_start(100, 8, 1'b1);
        @(negedge clk);
        base = ADDRW'(200); count = (ADDRW+1)'(3); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (issued - popped !== 2 || valid !== 1'b1) begin
            n_bad++; $display("FAIL prereset_buffered got %0d valid=%b want 2 valid=1", issued - popped, valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({valid, rd_req, busy, last} !== 4'b0000) begin
            n_bad++; $display("FAIL async_reset got valid/req/busy/last=%b want 0000", {valid, rd_req, busy, last});
        end
        q_addr.delete(); q_data.delete(); q_last.delete();
        issued = 0; popped = 0; stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL reset_no_done got %b want 0", done);
        end
        do_start(300, 3, 1'b1);
        wait_done(30, 1'b0, kd);
        n_cmp++;
        if (kd !== 6) begin
            n_bad++; $display("FAIL after_reset_done got T+%0d want T+6", kd);
        end
    endtask

    task automatic test_full_depth();
        int kd = -1;
        int beats = 0;
        int first_v = -1;
        int last_v = -1;
        ready = 1'b1;
        do_start(0, DEPTH, 1'b1);
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (valid) begin
                beats++;
                if (first_v < 0) first_v = k;
                last_v = k;
            end
            if (done) begin
                kd = k;
                break;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (kd !== DEPTH + 3) begin
            n_bad++; $display("FAIL full_done got T+%0d want T+%0d", kd, DEPTH + 3);
        end
        n_cmp++;
        if (beats !== DEPTH || first_v !== 3 || last_v !== DEPTH + 2) begin
            n_bad++; $display("FAIL full_beats got %0d in T+%0d..T+%0d want %0d in T+3..T+%0d", beats, first_v, last_v, DEPTH, DEPTH + 2);
        end
        n_cmp++;
        if (q_data.size() != 0) begin
            n_bad++; $display("FAIL full_leftover got %0d want 0", q_data.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_and_edge();
        test_wrap();
        test_ignore_and_reset();
        test_full_depth();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sdp_ram_reader.md
# sdp_ram_reader

Read-side sequencer for the simple dual-port line/frame RAM (`sdp_ram`). On a start command it streams `i_count` consecutive words beginning at `i_base_addr` out of the RAM's registered read port. It presents them as a valid/ready stream with full backpressure support and no lost or duplicated words. It sits between the frame buffer and downstream consumers (scaler, colour-map, HDMI/display pipeline), at one word per cycle when the sink never stalls.

## Interface

Parameters:
- `WIDTH`, 640: word width in bits; must equal the attached RAM's `WIDTH`.
- `DEPTH`, 480: RAM depth in words; must equal the attached RAM's `DEPTH`.
- `ADDRW`, $clog2(DEPTH): localparam, address width.

Ports:
- `i_clk`, input, 1: the block's single clock, shared with the RAM.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_start`, input, 1: start request; sampled only in IDLE.
- `i_base_addr`, input, ADDRW: first word address; captured on start.
- `i_count`, input, ADDRW+1: number of words to read, 0..DEPTH; captured on start.
- `o_busy`, output, 1: high in RUN and DRAIN.
- `o_done`, output, 1: one-cycle pulse when a transfer completes.
- `o_rd_req`, output, 1: RAM read enable; connects to the RAM's `i_rd_req`.
- `o_rd_addr`, output, ADDRW: RAM read address; connects to the RAM's `i_rd_addr`.
- `i_rd_data`, input, WIDTH: RAM read data; valid the cycle after `o_rd_req`.
- `o_data`, output, WIDTH: stream data.
- `o_valid`, output, 1: stream valid.
- `i_ready`, input, 1: stream ready from the sink.
- `o_last`, output, 1: high with the final word of the transfer.

## Operation

- **States:**
  - IDLE: accepts a start.
  - RUN: issuing reads.
  - DRAIN: all reads issued, waiting for the buffer to empty.
- **Reset values:**
  - State is IDLE.
  - `o_busy`, `o_done`, `o_rd_req`, `o_valid` and `o_last` are 0.
  - `o_rd_addr` and `o_data` are 0.
  - The buffer is empty and the in-flight flag is clear.
- **IDLE with `i_start` = 1:**
  - Capture base and count.
  - If count = 0, pulse `o_done` the next cycle and stay in IDLE.
  - Otherwise go to RUN.
- **`i_start` outside IDLE:** ignored.
- **Output buffer:** 2-entry FIFO. An in-flight flag marks a read issued in the previous cycle; that word is written to the FIFO the cycle it returns.
- **Read issue rule:** in RUN, `o_rd_req` = 1 iff (occupancy + inflight − pop) < 2, where pop = `o_valid & i_ready`.
  - `o_rd_req` is combinational from registered state and `i_ready`.
  - Each issue increments the address and decrements the remaining count.
- **Address sequence:** base, base+1, …, base+count−1, computed modulo DEPTH (see Configuration).
- **RUN → DRAIN:** when the last read is issued.
- **DRAIN → IDLE:** on the handshake of the word flagged `o_last`. `o_done` pulses in the following cycle.
- **Stream rules:**
  - `o_valid` = FIFO not empty.
  - `o_data` and `o_last` stay stable while `o_valid & !i_ready`.
  - `o_last` is asserted only on the word read from the address base+count−1.
- **Asynchronous reset mid-transfer:** immediate return to IDLE. In-flight and buffered words are discarded and no `o_done` is produced.

## Timing

- Start sampled at edge T:
  - `o_rd_req` = 1 with `o_rd_addr` = base during cycle T+1.
  - RAM data arrives in cycle T+2.
  - `o_valid` is first asserted in cycle T+3.
- With `i_ready` held high: one word per cycle, with no gaps after the first.
  - Transfer of N words: `o_done` pulses in cycle T+N+3.
- Sink stall: at most 2 words are buffered and at most 1 is in flight, so no word is ever overwritten. When `i_ready` rises again, throughput returns to one word per cycle with no bubble.
- Back-to-back transfers: a new `i_start` is accepted in the cycle `o_done` is high (the block is already in IDLE).

## Configuration

- Macro: `SDP_READER_WRAP_EN`.
- **Defined:** addresses wrap from DEPTH−1 to 0, so any base with count ≤ DEPTH is legal. This supports circular line buffers.
- **Undefined:**
  - A start with base + count > DEPTH is rejected. The block stays in IDLE, issues no reads, and pulses `o_done` the next cycle with no data.
  - Legal transfers behave identically to the wrapping build.

## Test plan

- Reset, then start with DEPTH=480, base=10, count=4, `i_ready`=1:
  - Reads are issued at 10, 11, 12, 13 in cycles T+1..T+4.
  - `o_valid` is asserted in T+3..T+6 with data mem[10..13].
  - `o_last` is high in T+6 and `o_done` pulses in T+7.
- Same transfer with `i_ready` toggling on a pseudo-random pattern:
  - Output order is exactly 10..13, with no duplicates or drops.
  - `o_data` is stable during stalls.
  - Occupancy never exceeds 2.
- count=0: no `o_rd_req`, no `o_valid`, and `o_done` pulses in T+1. Then count=1 at base 479: a single word with `o_last`=1.
- base=478, count=4:
  - With `SDP_READER_WRAP_EN`: addresses 478, 479, 0, 1.
  - Without it: no reads, and `o_done` pulses in T+1.
- `i_start` pulsed during RUN is ignored. Deasserting `i_rst_n` mid-transfer with 2 words buffered:
  - `o_valid`, `o_rd_req` and `o_busy` drop to 0 immediately.
  - A following start reads correctly from its new base.
- Full-depth transfer, count=480, base=0, `i_ready`=1: 480 consecutive beats, with `o_done` in T+483.
